epochtv1_vram_arb: RTL and testbench
====================================

// Module: epochtv1_vram_arb
// PURPOSE
// - Arbitrates the two 4 KiB x 8 VRAM banks (A, B) of the Epoch TV-1 between the
//   renderer (priority, 16-bit {B,A} fetch) and the CPU (8-bit read/write).
// - Sits between the epochtv1 core's internal requesters and the VAA/VBA
//   external SRAM pins, and owns all nVxRD/nVxWR strobe timing.
// - Prevents CPU starvation with a bounded wait counter.
// PARAMETERS
// - CPU_MAX_WAIT  4  renderer grants a pending CPU request may lose before the CPU is forced next
// - AW            12 VRAM bank address width
// PORTS
// - CLK    in  1  system clock (2x 14.318181 MHz); single clock domain
// - RES    in  1  reset, asynchronous, active-high
// - CE     in  1  pixel clock enable; FSM and counter advance only on CLK edges with CE=1
// - R_REQ  in  1  renderer fetch request, level
// - R_A    in  AW renderer word address, same for both banks
// - R_D    out 16 renderer data {VBD,VAD}
// - R_ACK  out 1  renderer completion, 1-CLK pulse
// - C_REQ  in  1  CPU request, level
// - C_WE   in  1  1=write, 0=read
// - C_A    in  13 CPU byte address; bit0=bank (0=A,1=B), [12:1]=bank address
// - C_DI   in  8  CPU write data
// - C_DO   out 8  CPU read data
// - C_ACK  out 1  CPU completion, 1-CLK pulse
// - VAA/VBA        out AW bank A/B address
// - VAD_I/VBD_I    in  8  bank A/B read data
// - VAD_O/VBD_O    out 8  bank A/B write data
// - nVARD/nVBRD    out 1  bank A/B read strobe, active-low
// - nVAWR/nVBWR    out 1  bank A/B write strobe, active-low
// - BUSY   out 1  access in flight (or write buffer full, see CONFIGURATION)
// BEHAVIOUR
// - Reset (async, immediate): FSM=IDLE; all strobes 1; VAA=VBA=0; VAD_O=VBD_O=0.
//   R_D=0, C_DO=0, R_ACK=C_ACK=0, BUSY=0, wait counter=0.
// - Reset mid-access: strobes released at once; no ACK issued; requester reissues.
// - FSM IDLE: requests sampled only on CE edges.
//   - Grant renderer if R_REQ and wait counter < CPU_MAX_WAIT.
//   - Otherwise grant CPU if C_REQ.
//   - Otherwise stay IDLE.
//   - Grant edge registers address and strobes, then -> ACC.
// - FSM ACC: strobes held low for exactly one CE period.
//   - Next CE edge: capture read data, strobes -> 1, ACK pulses for one CLK, -> IDLE.
//   - No re-grant on the completing edge; throughput is 1 access per 2 CE ticks.
//   - Latency is 2 CE edges from request sampled to ACK.
// - Requesters drop REQ before the next CE edge after ACK; a REQ still high there is a new request.
// - Renderer access: VAA=VBA=R_A; nVARD=nVBRD=0; R_D<={VBD_I,VAD_I}.
// - CPU access: only the selected bank's strobe is active; the other bank keeps its strobes high.
//   - Read: C_DO<=VxD_I.
//   - Write: VxD_O=C_DI, nVxWR=0; C_DO unchanged.
// - Wait counter:
//   - +1 (saturating at CPU_MAX_WAIT) on each renderer grant while C_REQ is high.
//   - Cleared on CPU grant or when C_REQ is low at a CE edge.
// - CE=0: all state and outputs hold, except the ACK self-clear on the next CLK.
// - R_REQ and C_REQ on the same edge with counter < max: renderer first, CPU at the next arbitration.
// CONFIGURATION
// - VRAM_WBUF_EN defined: one-entry posted CPU write buffer {bank,addr,data}.
//   - CPU write is accepted on a CE edge when the buffer is empty.
//   - C_ACK pulses on that edge's following CLK.
//   - Buffer drains through normal arbitration with CPU priority and counter rules.
//   - A CPU read while the buffer is full waits until the buffer drains.
//   - BUSY=1 while the buffer is full.
// - VRAM_WBUF_EN undefined: no buffer; write C_ACK only on VRAM completion.
// TESTING
// - Assert RES during ACC: nVARD/nVBRD/nVAWR/nVBWR=1 and ACKs=0 the same CLK; after release, FSM idle.
// - A[0x123]=0x5A, B[0x123]=0xC3; R_REQ, R_A=0x123:
//   nVARD=nVBRD=0 for one CE period, then R_ACK with R_D=0xC35A.
// - C_WE=1, C_A=0x0247, C_DI=0x77: nVBWR=0 one CE period at VBA=0x123 and nVAWR stays 1;
//   then a read of 0x0247 gives C_DO=0x77.
// - R_REQ held high and C_REQ raised: CPU granted right after exactly 4 renderer grants
//   (CPU_MAX_WAIT=4); counter then reads 0.
// - R_REQ and C_REQ rise on the same CE edge: renderer ACK first, CPU granted at the next idle CE edge.
// - VRAM_WBUF_EN with R_REQ saturating: write 0x0246<=0x99 acks one CE after accept;
//   a following read of 0x0246 returns 0x99.

Source files
------------

// File: rtl/epochtv1_vram_arb.sv
// Epoch TV-1 VRAM arbiter: renderer/CPU access to the two 4 KiB x 8 banks with bounded CPU wait.
// Optional VRAM_WBUF_EN adds a one-entry posted CPU write buffer.
module epochtv1_vram_arb #(
  parameter int CPU_MAX_WAIT = 4,
  parameter int AW           = 12
) (
  input  logic          CLK,
  input  logic          RES,
  input  logic          CE,
  input  logic          R_REQ,
  input  logic [AW-1:0] R_A,
  output logic [15:0]   R_D,
  output logic          R_ACK,
  input  logic          C_REQ,
  input  logic          C_WE,
  input  logic [AW:0]   C_A,
  input  logic [7:0]    C_DI,
  output logic [7:0]    C_DO,
  output logic          C_ACK,
  output logic [AW-1:0] VAA,
  output logic [AW-1:0] VBA,
  input  logic [7:0]    VAD_I,
  input  logic [7:0]    VBD_I,
  output logic [7:0]    VAD_O,
  output logic [7:0]    VBD_O,
  output logic          nVARD,
  output logic          nVBRD,
  output logic          nVAWR,
  output logic          nVBWR,
  output logic          BUSY
);
  localparam int CW = $clog2(CPU_MAX_WAIT + 1);
  localparam logic [CW-1:0] WMAX = CW'(CPU_MAX_WAIT);

  typedef enum logic {IDLE, ACC} state_t;
  state_t state;

  logic [CW-1:0] wcnt;
  logic          gnt_r, gnt_we, gnt_bank;
  logic          cpu_pend, c_bank, c_we, wb_full;
  logic [AW-1:0] c_addr;
  logic [7:0]    c_data;

`ifdef VRAM_WBUF_EN
  logic          wb_vld, wb_bank;
  logic [AW-1:0] wb_addr;
  logic [7:0]    wb_data;

  // Writes only reach VRAM through the buffer; a pending drain outranks CPU reads.
  always_comb begin
    cpu_pend = wb_vld | (C_REQ & ~C_WE);
    c_bank   = wb_vld ? wb_bank : C_A[0];
    c_we     = wb_vld;
    c_addr   = wb_vld ? wb_addr : C_A[AW:1];
    c_data   = wb_data;
  end
  assign wb_full = wb_vld;
`else
  assign cpu_pend = C_REQ;
  assign c_bank   = C_A[0];
  assign c_we     = C_WE;
  assign c_addr   = C_A[AW:1];
  assign c_data   = C_DI;
  assign wb_full  = 1'b0;
`endif

  assign BUSY = (state == ACC) | wb_full;

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      state    <= IDLE;
      wcnt     <= '0;
      gnt_r    <= 1'b0;
      gnt_we   <= 1'b0;
      gnt_bank <= 1'b0;
      VAA      <= '0;
      VBA      <= '0;
      VAD_O    <= '0;
      VBD_O    <= '0;
      nVARD    <= 1'b1;
      nVBRD    <= 1'b1;
      nVAWR    <= 1'b1;
      nVBWR    <= 1'b1;
      R_D      <= '0;
      C_DO     <= '0;
      R_ACK    <= 1'b0;
      C_ACK    <= 1'b0;
`ifdef VRAM_WBUF_EN
      wb_vld   <= 1'b0;
      wb_bank  <= 1'b0;
      wb_addr  <= '0;
      wb_data  <= '0;
`endif
    end else begin
      // ACKs are single-CLK pulses regardless of CE
      R_ACK <= 1'b0;
      C_ACK <= 1'b0;
      if (CE) begin
        if (!cpu_pend) wcnt <= '0;
`ifdef VRAM_WBUF_EN
        if (C_REQ && C_WE && !wb_vld) begin
          wb_vld  <= 1'b1;
          wb_bank <= C_A[0];
          wb_addr <= C_A[AW:1];
          wb_data <= C_DI;
          C_ACK   <= 1'b1;
        end
`endif
        case (state)
          IDLE: begin
            if (R_REQ && wcnt < WMAX) begin
              state <= ACC;
              gnt_r <= 1'b1;
              VAA   <= R_A;
              VBA   <= R_A;
              nVARD <= 1'b0;
              nVBRD <= 1'b0;
              if (cpu_pend) wcnt <= wcnt + CW'(1);
            end else if (cpu_pend) begin
              state    <= ACC;
              gnt_r    <= 1'b0;
              gnt_we   <= c_we;
              gnt_bank <= c_bank;
              wcnt     <= '0;
              if (c_bank) begin
                VBA <= c_addr;
                if (c_we) begin
                  VBD_O <= c_data;
                  nVBWR <= 1'b0;
                end else begin
                  nVBRD <= 1'b0;
                end
              end else begin
                VAA <= c_addr;
                if (c_we) begin
                  VAD_O <= c_data;
                  nVAWR <= 1'b0;
                end else begin
                  nVARD <= 1'b0;
                end
              end
            end
          end
          ACC: begin
            state <= IDLE;
            nVARD <= 1'b1;
            nVBRD <= 1'b1;
            nVAWR <= 1'b1;
            nVBWR <= 1'b1;
            if (gnt_r) begin
              R_D   <= {VBD_I, VAD_I};
              R_ACK <= 1'b1;
            end else begin
              if (!gnt_we) C_DO <= gnt_bank ? VBD_I : VAD_I;
`ifdef VRAM_WBUF_EN
              if (gnt_we) wb_vld <= 1'b0;
              else        C_ACK  <= 1'b1;
`else
              C_ACK <= 1'b1;
`endif
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_epochtv1_vram_arb.sv
// Bench for epochtv1_vram_arb: SRAM model, vector table, scoreboard of expected ACKs in order.
module tb_epochtv1_vram_arb;
  logic        CLK = 1'b0, RES, CE, R_REQ, R_ACK, C_REQ, C_WE, C_ACK, BUSY;
  logic        nVARD, nVBRD, nVAWR, nVBWR;
  logic [11:0] R_A, VAA, VBA;
  logic [15:0] R_D;
  logic [12:0] C_A;
  logic [7:0]  C_DI, C_DO, VAD_I, VBD_I, VAD_O, VBD_O;

  epochtv1_vram_arb dut (
    .CLK(CLK), .RES(RES), .CE(CE),
    .R_REQ(R_REQ), .R_A(R_A), .R_D(R_D), .R_ACK(R_ACK),
    .C_REQ(C_REQ), .C_WE(C_WE), .C_A(C_A), .C_DI(C_DI), .C_DO(C_DO), .C_ACK(C_ACK),
    .VAA(VAA), .VBA(VBA), .VAD_I(VAD_I), .VBD_I(VBD_I), .VAD_O(VAD_O), .VBD_O(VBD_O),
    .nVARD(nVARD), .nVBRD(nVBRD), .nVAWR(nVAWR), .nVBWR(nVBWR), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  // External SRAM banks, preloaded on the first reset
  logic [7:0] mem_a [4096];
  logic [7:0] mem_b [4096];
  logic       loaded = 1'b0;
  always @(posedge CLK) begin
    if (RES && !loaded) begin
      for (int i = 0; i < 4096; i++) begin
        mem_a[i] <= 8'h00;
        mem_b[i] <= 8'h00;
      end
      mem_a[12'h123] <= 8'h5A;
      mem_b[12'h123] <= 8'hC3;
      loaded <= 1'b1;
    end else begin
      if (!nVAWR) mem_a[VAA] <= VAD_O;
      if (!nVBWR) mem_b[VBA] <= VBD_O;
    end
  end
  assign VAD_I = mem_a[VAA];
  assign VBD_I = mem_b[VBA];

  typedef struct packed {logic cpu; logic [15:0] data;} sb_t;
  typedef struct {bit cpu; bit we; logic [12:0] a; logic [7:0] d; logic [15:0] exp;} vec_t;

  sb_t  sb[$];
  vec_t vt[14];
  int   errors = 0, checks = 0;
  bit   ce_run = 1'b1, r_ignore = 1'b0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(bit cpu, logic [15:0] d);
    sb_t e;
    e.cpu  = cpu;
    e.data = d;
    sb.push_back(e);
  endtask

  // One CLK step: advance CE at the negedge and score any ACK seen there
  task automatic tick();
    sb_t e;
    @(negedge CLK);
    CE = ce_run ? ~CE : 1'b0;
    if (R_ACK && !r_ignore) begin
      if (sb.size() == 0) chk("r_ack_unexpected", 32'd1, 32'd0);
      else begin
        e = sb.pop_front();
        chk("r_order", {31'd0, e.cpu}, 32'd0);
        chk("r_data", {16'd0, R_D}, {16'd0, e.data});
      end
    end
    if (C_ACK) begin
      if (sb.size() == 0) chk("c_ack_unexpected", 32'd1, 32'd0);
      else begin
        e = sb.pop_front();
        chk("c_order", {31'd0, e.cpu}, 32'd1);
        chk("c_do", {24'd0, C_DO}, {24'd0, e.data[7:0]});
      end
    end
  endtask

  task automatic wait_ack(bit cpu, int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      tick();
      if (cpu ? C_ACK : R_ACK) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_req(bit cpu, bit we, logic [12:0] a, logic [7:0] d);
    bit ok;
    if (cpu) begin
      C_REQ = 1'b1; C_WE = we; C_A = a; C_DI = d;
    end else begin
      R_REQ = 1'b1; R_A = a[11:0];
    end
    wait_ack(cpu, 40, ok);
    chk("ack_timeout", {31'd0, ok}, 32'd1);
    R_REQ = 1'b0;
    C_REQ = 1'b0;
  endtask

  initial begin
    bit ok, bad;
    int nlow, nr, tr, tc;
    vt[0]  = '{1'b0, 1'b0, 13'h0123, 8'h00, 16'hC35A};
    vt[1]  = '{1'b1, 1'b0, 13'h0246, 8'h00, 16'h005A};
    vt[2]  = '{1'b1, 1'b0, 13'h0247, 8'h00, 16'h00C3};
    vt[3]  = '{1'b1, 1'b1, 13'h0247, 8'h77, 16'h00C3};
    vt[4]  = '{1'b1, 1'b0, 13'h0247, 8'h00, 16'h0077};
    vt[5]  = '{1'b1, 1'b0, 13'h0246, 8'h00, 16'h005A};
    vt[6]  = '{1'b0, 1'b0, 13'h0123, 8'h00, 16'h775A};
    vt[7]  = '{1'b1, 1'b1, 13'h0000, 8'h11, 16'h005A};
    vt[8]  = '{1'b1, 1'b1, 13'h0001, 8'h22, 16'h005A};
    vt[9]  = '{1'b0, 1'b0, 13'h0000, 8'h00, 16'h2211};
    vt[10] = '{1'b1, 1'b1, 13'h1FFF, 8'hEE, 16'h005A};
    vt[11] = '{1'b0, 1'b0, 13'h0FFF, 8'h00, 16'hEE00};
    vt[12] = '{1'b1, 1'b0, 13'h1FFE, 8'h00, 16'h0000};
    vt[13] = '{1'b1, 1'b0, 13'h1FFF, 8'h00, 16'h00EE};

    RES = 1'b1; CE = 1'b0; R_REQ = 1'b0; R_A = '0;
    C_REQ = 1'b0; C_WE = 1'b0; C_A = '0; C_DI = '0;
    repeat (4) tick();
    chk("rst_strobes", {28'd0, nVARD, nVBRD, nVAWR, nVBWR}, 32'hF);
    chk("rst_addr", {8'd0, VAA, VBA}, 32'd0);
    chk("rst_wdata", {16'd0, VAD_O, VBD_O}, 32'd0);
    chk("rst_rdata", {8'd0, R_D, C_DO}, 32'd0);
    chk("rst_ack_busy", {29'd0, R_ACK, C_ACK, BUSY}, 32'd0);
    RES = 1'b0;
    repeat (2) tick();

    // Reset in the middle of a renderer access, with CE paused first
    R_REQ = 1'b1; R_A = 12'h123; ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!nVARD) begin ok = 1'b1; break; end
    end
    chk("rm_grant", {31'd0, ok}, 32'd1);
    chk("rm_strb", {28'd0, nVARD, nVBRD, nVAWR, nVBWR}, 32'h3);
    ce_run = 1'b0; bad = 1'b0;
    repeat (6) begin
      tick();
      if (nVARD || nVBRD || R_ACK || !BUSY) bad = 1'b1;
    end
    chk("ce_hold", {31'd0, bad}, 32'd0);
    RES = 1'b1;
    #1;
    chk("rm_strobes", {28'd0, nVARD, nVBRD, nVAWR, nVBWR}, 32'hF);
    chk("rm_acks_busy", {29'd0, R_ACK, C_ACK, BUSY}, 32'd0);
    R_REQ = 1'b0;
    repeat (2) tick();
    RES = 1'b0; ce_run = 1'b1;
    repeat (8) tick();
    chk("rm_idle", {30'd0, BUSY, nVARD}, 32'd1);

    for (int i = 0; i < 14; i++) begin
      push(vt[i].cpu, vt[i].exp);
      do_req(vt[i].cpu, vt[i].we, vt[i].a, vt[i].d);
    end

`ifndef VRAM_WBUF_EN
    // CPU write to bank B: only nVBWR active, for one CE period
    push(1'b1, 16'h00EE);
    C_REQ = 1'b1; C_WE = 1'b1; C_A = 13'h0247; C_DI = 8'h77;
    nlow = 0; bad = 1'b0; ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!nVBWR) begin
        nlow++;
        if (VBA !== 12'h123 || VBD_O !== 8'h77) bad = 1'b1;
      end
      if (!nVAWR || !nVARD || !nVBRD) bad = 1'b1;
      if (C_ACK) begin ok = 1'b1; break; end
    end
    C_REQ = 1'b0;
    chk("wr_ack", {31'd0, ok}, 32'd1);
    chk("wr_strobe_len", nlow, 32'd2);
    chk("wr_other_bank", {31'd0, bad}, 32'd0);
    chk("wr_release", {31'd0, nVBWR}, 32'd1);
`endif
    push(1'b1, 16'h0077);
    do_req(1'b1, 1'b0, 13'h0247, 8'h00);

    // Same-edge requests: renderer first, CPU one CE period later
    push(1'b0, 16'h775A);
    push(1'b1, 16'h0077);
    R_REQ = 1'b1; R_A = 12'h123; C_REQ = 1'b1; C_WE = 1'b0; C_A = 13'h0247;
    tr = -100; tc = 0; ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (R_ACK) begin R_REQ = 1'b0; tr = i; end
      if (C_ACK) begin tc = i; ok = 1'b1; break; end
    end
    C_REQ = 1'b0;
    chk("same_edge_ack", {31'd0, ok}, 32'd1);
    chk("same_edge_gap", tc - tr, 32'd4);

    // Starvation bound, twice to show the counter restarts from zero
    push(1'b0, 16'h775A);
    R_REQ = 1'b1; R_A = 12'h123;
    wait_ack(1'b0, 40, ok);
    chk("starve_first_r", {31'd0, ok}, 32'd1);
    for (int rnd = 0; rnd < 2; rnd++) begin
      repeat (4) push(1'b0, 16'h775A);
      push(1'b1, 16'h005A);
      C_REQ = 1'b1; C_WE = 1'b0; C_A = 13'h0246; nr = 0; ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
        tick();
        if (R_ACK) nr++;
        if (C_ACK) begin ok = 1'b1; break; end
      end
      C_REQ = 1'b0;
      chk("starve_c_ack", {31'd0, ok}, 32'd1);
      chk("starve_r_count", nr, 32'd4);
      if (rnd == 0) begin
        push(1'b0, 16'h775A);
        wait_ack(1'b0, 40, ok);
        chk("starve_resume_r", {31'd0, ok}, 32'd1);
      end
    end
    R_REQ = 1'b0;
    repeat (6) tick();

`ifdef VRAM_WBUF_EN
    // Posted write while the renderer saturates the banks
    r_ignore = 1'b1;
    R_REQ = 1'b1; R_A = 12'h000;
    repeat (4) tick();
    push(1'b1, 16'h005A);
    C_REQ = 1'b1; C_WE = 1'b1; C_A = 13'h0246; C_DI = 8'h99; nr = 0; ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      nr++;
      if (C_ACK) begin ok = 1'b1; break; end
    end
    C_REQ = 1'b0;
    chk("wb_ack", {31'd0, ok}, 32'd1);
    chk("wb_ack_fast", {31'd0, nr <= 2}, 32'd1);
    push(1'b1, 16'h0099);
    C_REQ = 1'b1; C_WE = 1'b0; C_A = 13'h0246;
    wait_ack(1'b1, 200, ok);
    C_REQ = 1'b0;
    chk("wb_read_ack", {31'd0, ok}, 32'd1);
    R_REQ = 1'b0;
    repeat (6) tick();
    r_ignore = 1'b0;
`endif

    chk("sb_drained", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
